// File: rtl/rope_pkg.sv
// Shared types and constants for the rope fire controller.
package rope_pkg;

   localparam int unsigned PIX_W       = 11;
   localparam int unsigned SHOT_W      = 8;
   localparam int unsigned Y_FRAME_MAX = 479;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      FLY,
      HIDE,
      COOL
   } rope_state_t;

   // Rope X is the player X plus the sprite-centre offset, clamped to the right screen edge.
   function automatic logic [PIX_W-1:0] rope_x_sat(input logic [PIX_W-1:0] px,
                                                   input int unsigned     offset,
                                                   input int unsigned     xmax);
      int unsigned sum;
      sum = 32'(px) + offset;
      if (sum > xmax) begin
         return xmax[PIX_W-1:0];
      end
      return sum[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/rope_fire_if.sv
// Signal bundle between the game environment and the rope fire controller.
// The master side drives frame timing, the key, player position and trajectory feedback;
// the slave side (the controller) returns deploy, rope X/visibility and shot bookkeeping.
interface rope_fire_if;
   import rope_pkg::*;

   logic              startOfFrame;
   logic              fireKey;
   logic              gameActive;
   logic [PIX_W-1:0]  playerX;
   logic              ropeMovingUp;
   logic              ropeHit;

   logic              deploy;
   logic [PIX_W-1:0]  ropeX;
   logic              ropeVisible;
   logic              ropeBusy;
   logic              fireAccepted;
   logic [SHOT_W-1:0] shotCount;

   modport master (
      output startOfFrame, fireKey, gameActive, playerX, ropeMovingUp, ropeHit,
      input  deploy, ropeX, ropeVisible, ropeBusy, fireAccepted, shotCount
   );

   modport slave (
      input  startOfFrame, fireKey, gameActive, playerX, ropeMovingUp, ropeHit,
      output deploy, ropeX, ropeVisible, ropeBusy, fireAccepted, shotCount
   );

endinterface

// File: rtl/fire_sync_edge.sv
// Two-flop synchronizer for the raw fire key followed by a rising-edge detector.
// rise is combinational from the flops, so the FSM acts on it three clocks after the key changes.
module fire_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);

   logic s1_q;
   logic s2_q;
   logic prev_q;

   // Synchronizer chain plus one delayed copy for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= din;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign level = s2_q;
   assign rise  = s2_q & ~prev_q;

endmodule

// File: rtl/rope_fire_ctrl.sv
// Rope fire controller: turns the fire key into a frame-aligned deploy request, keeps one rope
// in flight at a time, tracks its lifetime and counts accepted shots.
// Optional build macro ROPE_AUTOFIRE_EN: a held key fires on level and repeats after cooldown.
module rope_fire_ctrl
   import rope_pkg::*;
#(
   parameter int unsigned COOLDOWN_FRAMES = 4,
   parameter int unsigned ROPE_X_OFFSET   = 16,
   parameter int unsigned X_MAX           = 639
) (
   input logic        clk,
   input logic        reset,
   rope_fire_if.slave bus
);

   localparam int unsigned CntW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

   rope_state_t       state_q, state_d;
   logic [CntW-1:0]   cool_q, cool_d;
   logic [PIX_W-1:0]  rope_x_q, rope_x_d;
   logic [SHOT_W-1:0] shots_q, shots_d;
   logic              fire_acc_q, fire_acc_d;
   logic              armed_q, armed_d;
   logic              fly_first_q, fly_first_d;

   logic              key_level;
   logic              key_rise;
   logic              fire_req;

   fire_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (bus.fireKey),
      .level (key_level),
      .rise  (key_rise)
   );

`ifdef ROPE_AUTOFIRE_EN
   assign fire_req = key_level & armed_q;
`else
   assign fire_req = key_rise & armed_q;
`endif

   // State, counters and latched rope data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cool_q      <= '0;
         rope_x_q    <= '0;
         shots_q     <= '0;
         fire_acc_q  <= 1'b0;
         armed_q     <= 1'b1;
         fly_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cool_q      <= cool_d;
         rope_x_q    <= rope_x_d;
         shots_q     <= shots_d;
         fire_acc_q  <= fire_acc_d;
         armed_q     <= armed_d;
         fly_first_q <= fly_first_d;
      end
   end

   // Next-state logic for the rope lifetime FSM and its side effects.
   always_comb begin
      state_d     = state_q;
      cool_d      = cool_q;
      rope_x_d    = rope_x_q;
      shots_d     = shots_q;
      fire_acc_d  = 1'b0;
      fly_first_d = 1'b0;
`ifdef ROPE_AUTOFIRE_EN
      armed_d     = 1'b1;
`else
      // Re-arm only once the key has been seen released.
      armed_d     = key_level ? armed_q : 1'b1;
`endif

      unique case (state_q)
         IDLE: begin
            if (fire_req && bus.gameActive) begin
               state_d    = ARM;
               rope_x_d   = rope_x_sat(bus.playerX, ROPE_X_OFFSET, X_MAX);
               fire_acc_d = 1'b1;
               if (shots_q != '1) begin
                  shots_d = shots_q + SHOT_W'(1);
               end
`ifndef ROPE_AUTOFIRE_EN
               armed_d    = 1'b0;
`endif
            end
         end
         ARM: begin
            // The trajectory stage samples deploy only on startOfFrame.
            if (bus.startOfFrame) begin
               state_d     = FLY;
               fly_first_d = 1'b1;
            end
         end
         FLY: begin
            if (bus.ropeHit || !bus.gameActive) begin
               state_d = HIDE;
            end else if (!fly_first_q && !bus.ropeMovingUp) begin
               // movingUp lags deploy by a clock, so the first FLY cycle cannot end the rope.
               state_d = COOL;
               cool_d  = CntW'(COOLDOWN_FRAMES);
            end
         end
         HIDE: begin
            // The trajectory cannot be aborted; stay hidden until it finishes rising.
            if (!bus.ropeMovingUp) begin
               state_d = COOL;
               cool_d  = CntW'(COOLDOWN_FRAMES);
            end
         end
         COOL: begin
            if (COOLDOWN_FRAMES == 0) begin
               state_d = IDLE;
            end else if (bus.startOfFrame) begin
               if (cool_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cool_d = cool_q - CntW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state.
   always_comb begin
      bus.deploy       = (state_q == ARM);
      bus.ropeVisible  = (state_q == ARM) || (state_q == FLY);
      bus.ropeBusy     = (state_q != IDLE);
      bus.ropeX        = rope_x_q;
      bus.fireAccepted = fire_acc_q;
      bus.shotCount    = shots_q;
   end

endmodule

// File: tb/tb_rope_fire_ctrl.sv
// Scoreboard bench for rope_fire_ctrl: stimulus pushes expected events, a monitor pops them
// as the controller produces fire / deploy-end / hide / idle / reset events.
module tb_rope_fire_ctrl;
   import rope_pkg::*;

   localparam int FRAME = 8;
   localparam int EvFire = 0, EvFly = 1, EvVisOff = 2, EvIdle = 3, EvRst = 4;

   typedef struct {
      int kind;
      int v0;
      int v1;
      int v2;
      int v3;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rope_fire_if bus ();

   rope_fire_ctrl #(
      .COOLDOWN_FRAMES (4),
      .ROPE_X_OFFSET   (16),
      .X_MAX           (639)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   ev_t   exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    exp_shots = 0;
   string kname[5] = '{"fire", "fly", "visoff", "idle", "reset"};

   // Trajectory stage model state
   int    up_frames = 10;
   int    mu_fr = 0;
   bit    mu = 1'b0;
   bit    sof_prev_e = 1'b0;
   bit    dep_prev_e = 1'b0;
   int    fc = 0;

   function automatic void got(input ev_t a);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got v=%0d/%0d/%0d/%0d, required no event",
                  kname[a.kind], a.v0, a.v1, a.v2, a.v3);
         return;
      end
      e = exp_q.pop_front();
      if (e.kind != a.kind || (e.v0 != -1 && e.v0 != a.v0) || (e.v1 != -1 && e.v1 != a.v1) ||
          (e.v2 != -1 && e.v2 != a.v2) || (e.v3 != -1 && e.v3 != a.v3)) begin
         errors++;
         $display("FAIL %s: got %s v=%0d/%0d/%0d/%0d, required %s v=%0d/%0d/%0d/%0d",
                  kname[e.kind], kname[a.kind], a.v0, a.v1, a.v2, a.v3,
                  kname[e.kind], e.v0, e.v1, e.v2, e.v3);
      end
   endfunction

   function automatic int exp_x(input int x);
      return (x + 16 > 639) ? 639 : x + 16;
   endfunction

   // Frame pulse generator and trajectory stage model (movingUp high for up_frames frames).
   initial begin
      bus.startOfFrame = 1'b0;
      bus.ropeMovingUp = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            mu    = 1'b0;
            mu_fr = 0;
         end else if (sof_prev_e && dep_prev_e) begin
            mu    = 1'b1;
            mu_fr = up_frames;
         end else if (sof_prev_e && mu) begin
            mu_fr--;
            if (mu_fr == 0) mu = 1'b0;
         end
         bus.ropeMovingUp = mu;
         fc = (fc + 1) % FRAME;
         bus.startOfFrame = (fc == 0);
         sof_prev_e = bus.startOfFrame;
         dep_prev_e = bus.deploy;
      end
   end

   // Monitor: turns output transitions into events and hands them to the scoreboard.
   initial begin
      int cyc = 0, key_rise_cyc = 0, dep_fall_cyc = 0, sofs = 0;
      bit rst_p = 0, key_p = 0, dep_p = 0, vis_p = 0, busy_p = 0, sof_p = 0, hit_p = 0, mu_p = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            if (!rst_p) begin
               got('{EvRst, int'(bus.ropeX), int'(bus.shotCount),
                     int'({bus.deploy, bus.ropeVisible, bus.ropeBusy, bus.fireAccepted}), 0});
            end
            rst_p  = 1'b1;
            key_p  = bus.fireKey;
            dep_p  = bus.deploy;
            vis_p  = bus.ropeVisible;
            busy_p = bus.ropeBusy;
            sof_p  = bus.startOfFrame;
            hit_p  = bus.ropeHit;
            mu_p   = bus.ropeMovingUp;
            continue;
         end
         rst_p = 1'b0;
         if (bus.fireKey && !key_p) key_rise_cyc = cyc;
         if (bus.fireAccepted) begin
            got('{EvFire, int'(bus.ropeX), int'(bus.shotCount), cyc - key_rise_cyc,
                  int'(bus.deploy & bus.ropeVisible & bus.ropeBusy)});
         end
         if (dep_p && !bus.deploy) begin
            got('{EvFly, int'(sof_p), 0, 0, 0});
            dep_fall_cyc = cyc;
         end
         if (vis_p && !bus.ropeVisible) begin
            got('{EvVisOff, int'(hit_p), cyc - dep_fall_cyc, int'(bus.ropeBusy), 0});
         end
         if (busy_p && !bus.ropeBusy) begin
            got('{EvIdle, sofs, 0, 0, 0});
         end
         if (mu_p && !bus.ropeMovingUp) sofs = 0;
         else if (bus.startOfFrame) sofs++;
         key_p  = bus.fireKey;
         dep_p  = bus.deploy;
         vis_p  = bus.ropeVisible;
         busy_p = bus.ropeBusy;
         sof_p  = bus.startOfFrame;
         hit_p  = bus.ropeHit;
         mu_p   = bus.ropeMovingUp;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_shot(input int x, input int lat);
      if (exp_shots < 255) exp_shots++;
      exp_q.push_back(ev_t'{EvFire, exp_x(x), exp_shots, lat, 1});
      exp_q.push_back(ev_t'{EvFly, 1, -1, -1, -1});
   endtask

   task automatic expect_end(input int hit, input int since_fly);
      exp_q.push_back(ev_t'{EvVisOff, hit, since_fly, 1, -1});
      exp_q.push_back(ev_t'{EvIdle, 5, -1, -1, -1});
   endtask

   task automatic press(input int x);
      bus.playerX = 11'(x);
      bus.fireKey = 1'b1;
   endtask

   task automatic wait_cond(input int which, input int maxc);
      int n = 0;
      bit done;
      forever begin
         case (which)
            0:       done = !bus.ropeBusy;
            1:       done = bus.ropeVisible && !bus.deploy;
            default: done = bus.fireAccepted;
         endcase
         if (done || n >= maxc) break;
         tick(1);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL wait_%0d timeout: condition still false after %0d cycles, required true",
                  which, maxc);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.fireKey = 1'b0;
      bus.playerX = '0;
      bus.gameActive = 1'b1;
      bus.ropeHit = 1'b0;
      exp_q.push_back(ev_t'{EvRst, 0, 0, 0, 0});
      tick(3);
      reset = 1'b0;
      tick(2);

      // Basic shot: x=100 -> 116, rope rises 10 frames, 4-frame cooldown.
      up_frames = 10;
      expect_shot(100, 3);
      expect_end(0, -1);
      press(100);
      tick(4);
      bus.fireKey = 1'b0;
      wait_cond(0, FRAME * 20);
      tick(3);

      // Ball hit in the third FLY frame; an extra key press mid-flight is ignored.
      expect_shot(200, 3);
      expect_end(1, -1);
      press(200);
      tick(4);
      bus.fireKey = 1'b0;
      wait_cond(1, FRAME * 3);
      tick(3);
      bus.fireKey = 1'b1;
      tick(3);
      bus.fireKey = 1'b0;
      tick(2 * FRAME - 4);
      bus.ropeHit = 1'b1;
      tick(1);
      bus.ropeHit = 1'b0;
      wait_cond(0, FRAME * 20);
      tick(3);

      // gameActive drops while ARM: deploy completes, first FLY cycle hides the rope.
      up_frames = 3;
      expect_shot(300, 3);
      expect_end(0, 1);
      press(300);
      wait_cond(2, 10);
      bus.gameActive = 1'b0;
      tick(1);
      bus.fireKey = 1'b0;
      wait_cond(0, FRAME * 20);
      bus.gameActive = 1'b1;
      tick(3);

      // Key held through the whole cooldown.
      up_frames = 2;
      expect_shot(50, 3);
      expect_end(0, -1);
`ifdef ROPE_AUTOFIRE_EN
      expect_shot(50, -1);
      expect_end(0, -1);
`endif
      press(50);
      tick(4);
      wait_cond(0, FRAME * 20);
      tick(FRAME * 4);
      bus.fireKey = 1'b0;
      wait_cond(0, FRAME * 20);
      tick(3);

      // Saturation: X clamp and 256 shots so the counter pins at 255.
      up_frames = 1;
      for (int i = 0; i < 256; i++) begin
         int x;
         x = (i == 0) ? 630 : (i == 1) ? 623 : (i == 2) ? 0 : (i * 37) % 1024;
         expect_shot(x, 3);
         expect_end(0, -1);
         press(x);
         tick(4);
         bus.fireKey = 1'b0;
         wait_cond(0, FRAME * 20);
         tick(2);
      end

      // Reset in flight, then a fire right at reset release.
      up_frames = 10;
      expect_shot(10, 3);
      exp_q.push_back(ev_t'{EvRst, 0, 0, 0, 0});
      press(10);
      tick(4);
      bus.fireKey = 1'b0;
      wait_cond(1, FRAME * 3);
      tick(FRAME);
      reset = 1'b1;
      exp_shots = 0;
      tick(3);
      expect_shot(400, 3);
      expect_end(0, -1);
      reset = 1'b0;
      press(400);
      tick(4);
      bus.fireKey = 1'b0;
      wait_cond(0, FRAME * 20);

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_%s: got no event, required v=%0d/%0d/%0d/%0d",
                  kname[e.kind], e.v0, e.v1, e.v2, e.v3);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
